// File: rtl/div_pkg.sv
// Shared types and helpers for the sequential signed divider.
// Latency: n/a (declarations and a combinational helper only).
// Backpressure: n/a.
//
// Contents:
//   state_t  - FSM encoding (IDLE=00, CALC=01, SIGN=11; 10 is unused)
//   abs_w    - w-bit unsigned magnitude of a w-bit two's-complement value
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        SIGN = 2'b11
    } state_t;

    // Operands are passed zero-extended to 64 bits together with their real
    // width w (1..64); the result is masked back to w bits, so the magnitude
    // of the most negative value (2^(w-1)) is still representable unsigned.
    function automatic logic [63:0] abs_w(input logic [63:0] x, input int w);
        logic [63:0] mask;
        logic [63:0] neg;
        mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        neg  = (~x + 64'd1) & mask;
        return x[6'(w - 1)] ? neg : (x & mask);
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// One restoring-division step: trial-subtract the divisor from the shifted partial remainder.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle, the caller decides when to register it.
//
// Ports:
//   pr_i     - current partial remainder (W+1 bits)
//   n_msb_i  - next dividend bit shifted into the partial remainder
//   mag_d_i  - divisor magnitude
//   pr_o     - next partial remainder
//   q_bit_o  - quotient bit produced by this step
module div_restore_step #(
    parameter int W = 8
) (
    input  logic [W:0]   pr_i,
    input  logic         n_msb_i,
    input  logic [W-1:0] mag_d_i,
    output logic [W:0]   pr_o,
    output logic         q_bit_o
);

    logic [W+1:0] shifted;
    logic [W+1:0] trial;

    // Carried one bit wider than the partial remainder so the sign of the
    // trial difference is unambiguous whatever the partial remainder holds.
    assign shifted = {pr_i, n_msb_i};
    assign trial   = shifted - {2'b00, mag_d_i};

    assign q_bit_o = ~trial[W+1];
    assign pr_o    = q_bit_o ? trial[W:0] : shifted[W:0];

endmodule

// File: rtl/signed_div_fsm.sv
// Sequential radix-2 signed divider (truncating; remainder takes the dividend's sign).
// Latency: done pulses DATAWIDTH+1 edges after the accepting edge, for every operand pair.
// Backpressure: en is only sampled in IDLE; requests while busy are dropped, not queued.
//
// Ports:
//   clk, rstn          - clock, asynchronous active-low reset
//   en                 - start request, accepted in IDLE together with dividend/divisor
//   busy               - high while an operation is in flight
//   done               - one-cycle pulse, quotient/remainder/div_by_zero valid while high
//   quotient/remainder - signed results, held until the next done
//   div_by_zero        - qualifies the held result
module signed_div_fsm
    import div_pkg::*;
#(
    parameter int DATAWIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic [DATAWIDTH-1:0] dividend,
    input  logic [DATAWIDTH-1:0] divisor,
    output logic                 busy,
    output logic                 done,
    output logic [DATAWIDTH-1:0] quotient,
    output logic [DATAWIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    localparam int W  = DATAWIDTH;
    localparam int CW = $clog2(DATAWIDTH) + 1;

    state_t         state_q, state_d;
    logic [W-1:0]   mag_n_q;     // dividend magnitude, becomes the quotient magnitude
    logic [W-1:0]   mag_d_q;
    logic [W-1:0]   dividend_q;  // kept verbatim for the divide-by-zero remainder
    logic [W:0]     pr_q;
    logic [CW-1:0]  iter_q;
    logic           neg_q_q;
    logic           neg_r_q;
    logic           dz_q;
    logic           done_q;
    logic [W-1:0]   quotient_q;
    logic [W-1:0]   remainder_q;
    logic           div_by_zero_q;

    logic [W:0]     pr_step;
    logic           q_bit;
    logic           last_iter;

    div_restore_step #(.W(W)) u_step (
        .pr_i    (pr_q),
        .n_msb_i (mag_n_q[W-1]),
        .mag_d_i (mag_d_q),
        .pr_o    (pr_step),
        .q_bit_o (q_bit)
    );

    assign last_iter = (iter_q == CW'(W - 1));

    // Anything unrecognised (the spare 2'b10 encoding) falls back to IDLE.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = en ? CALC : IDLE;
            CALC:    state_d = last_iter ? SIGN : CALC;
            SIGN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            mag_n_q       <= '0;
            mag_d_q       <= '0;
            dividend_q    <= '0;
            pr_q          <= '0;
            iter_q        <= '0;
            neg_q_q       <= 1'b0;
            neg_r_q       <= 1'b0;
            dz_q          <= 1'b0;
            done_q        <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (en) begin
                        mag_n_q    <= W'(abs_w(64'(dividend), W));
                        mag_d_q    <= W'(abs_w(64'(divisor), W));
                        dividend_q <= dividend;
                        neg_q_q    <= dividend[W-1] ^ divisor[W-1];
                        neg_r_q    <= dividend[W-1];
                        dz_q       <= (divisor == '0);
                        pr_q       <= '0;
                        iter_q     <= '0;
                    end
                end
                CALC: begin
                    // mag_n doubles as the quotient shift register: dividend
                    // bits leave at the top while quotient bits enter below.
                    pr_q    <= pr_step;
                    mag_n_q <= {mag_n_q[W-2:0], q_bit};
                    iter_q  <= iter_q + CW'(1);
                end
                SIGN: begin
                    done_q        <= 1'b1;
                    div_by_zero_q <= dz_q;
                    // Divide-by-zero results are forced so they never depend
                    // on what the datapath happened to compute.
                    quotient_q    <= dz_q ? '1
                                   : (neg_q_q ? W'(-mag_n_q) : mag_n_q);
                    remainder_q   <= dz_q ? dividend_q
                                   : (neg_r_q ? W'(-pr_q[W-1:0]) : pr_q[W-1:0]);
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_div_fsm.sv
module tb_signed_div_fsm;

    logic       clk;
    logic       rstn;
    logic       en;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int checks   = 0;
    int failures = 0;

    signed_div_fsm #(.DATAWIDTH(8)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .en          (en),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // C-style reference: truncating division, remainder with the dividend's sign.
    function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                    output logic [7:0] q, output logic [7:0] r,
                                    output logic dz);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = int'($signed(b));
        if (bi == 0) begin
            q  = 8'hFF;
            r  = a;
            dz = 1'b1;
        end else begin
            q  = 8'(ai / bi);
            r  = 8'(ai % bi);
            dz = 1'b0;
        end
    endfunction

    // Called #1 after a rising edge with the DUT in IDLE. Returns the results,
    // the number of edges from the accepting edge to done, and busy cycles.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] q, output logic [7:0] r,
                          output logic dz, output int lat, output int busy_n);
        int i;
        lat      = -1;
        busy_n   = 0;
        dividend = a;
        divisor  = b;
        en       = 1'b1;
        @(posedge clk); #1;
        en       = 1'b0;
        dividend = ~a;
        divisor  = b + 8'd3;
        if (busy) busy_n++;
        i = 1;
        while (lat < 0 && i <= 20) begin
            @(posedge clk); #1;
            if (done) lat = i;
            else if (busy) busy_n++;
            i++;
        end
        q  = quotient;
        r  = remainder;
        dz = div_by_zero;
    endtask

    task automatic test_reset();
        rstn     = 1'b0;
        en       = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h dz=%b, expected all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        en   = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: got busy=%b done=%b, expected 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        logic [7:0] q, r;
        logic       dz;
        int         lat, bn;
        run_op(8'd100, 8'd7, q, r, dz, lat, bn);
        checks++;
        if ({q, r, dz} !== {8'h0E, 8'h02, 1'b0}) begin
            failures++;
            $display("FAIL basic_100_7: got q=%h r=%h dz=%b, expected q=0e r=02 dz=0", q, r, dz);
        end
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL basic_latency: got %0d edges, expected 9", lat);
        end
        checks++;
        if (bn !== 9) begin
            failures++;
            $display("FAIL basic_busy_cycles: got %0d, expected 9", bn);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || quotient !== 8'h0E || remainder !== 8'h02) begin
            failures++;
            $display("FAIL basic_pulse_hold: got done=%b q=%h r=%h, expected done=0 q=0e r=02",
                     done, quotient, remainder);
        end
    endtask

    task automatic test_sign_matrix();
        logic [7:0] ta [0:2];
        logic [7:0] tb [0:2];
        logic [7:0] tq [0:2];
        logic [7:0] tr [0:2];
        logic [7:0] q, r;
        logic       dz;
        int         lat, bn;
        ta = '{8'h9C, 8'h64, 8'h9C};
        tb = '{8'h07, 8'hF9, 8'hF9};
        tq = '{8'hF2, 8'hF2, 8'h0E};
        tr = '{8'hFE, 8'h02, 8'hFE};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], q, r, dz, lat, bn);
            checks++;
            if ({q, r, dz} !== {tq[i], tr[i], 1'b0} || lat !== 9) begin
                failures++;
                $display("FAIL sign_matrix_%0d: got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=0 lat=9",
                         i, q, r, dz, lat, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_corners();
        logic [7:0] ta [0:3];
        logic [7:0] tb [0:3];
        logic [7:0] tq [0:3];
        logic [7:0] tr [0:3];
        logic [7:0] q, r;
        logic       dz;
        int         lat, bn;
        ta = '{8'h80, 8'h80, 8'h7F, 8'h05};
        tb = '{8'hFF, 8'h01, 8'h7F, 8'h09};
        tq = '{8'h80, 8'h80, 8'h01, 8'h00};
        tr = '{8'h00, 8'h00, 8'h00, 8'h05};
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb[i], q, r, dz, lat, bn);
            checks++;
            if ({q, r, dz} !== {tq[i], tr[i], 1'b0} || lat !== 9) begin
                failures++;
                $display("FAIL corner_%0d: got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=0 lat=9",
                         i, q, r, dz, lat, tq[i], tr[i]);
            end
        end
    endtask

    task automatic test_div_zero();
        logic [7:0] q, r;
        logic       dz;
        int         lat, bn;
        run_op(8'd37, 8'd0, q, r, dz, lat, bn);
        checks++;
        if ({q, r, dz} !== {8'hFF, 8'h25, 1'b1}) begin
            failures++;
            $display("FAIL div_zero_37_0: got q=%h r=%h dz=%b, expected q=ff r=25 dz=1", q, r, dz);
        end
        checks++;
        if (lat !== 9) begin
            failures++;
            $display("FAIL div_zero_latency: got %0d edges, expected 9", lat);
        end
        run_op(8'd37, 8'd5, q, r, dz, lat, bn);
        checks++;
        if ({q, r, dz} !== {8'h07, 8'h02, 1'b0}) begin
            failures++;
            $display("FAIL div_zero_recover: got q=%h r=%h dz=%b, expected q=07 r=02 dz=0", q, r, dz);
        end
    endtask

    // en held high for 30 edges with fresh operands before each edge; only
    // edges 0, 10 and 20 find the divider idle.
    task automatic test_back_to_back();
        logic [7:0] eq [0:2];
        logic [7:0] er [0:2];
        int         dcount;
        eq = '{8'h0E, 8'hF2, 8'hF0};
        er = '{8'h02, 8'hFE, 8'h02};
        dcount = 0;
        en = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            if (done) begin
                if (dcount < 3) begin
                    checks++;
                    if (c !== 9 + 10 * dcount || quotient !== eq[dcount] || remainder !== er[dcount]) begin
                        failures++;
                        $display("FAIL b2b_result_%0d: got edge=%0d q=%h r=%h, expected edge=%0d q=%h r=%h",
                                 dcount, c, quotient, remainder, 9 + 10 * dcount, eq[dcount], er[dcount]);
                    end
                end
                dcount++;
            end
            if (c == 29) begin
                en = 1'b0;
            end else if (c + 1 == 10) begin
                dividend = 8'h9C;
                divisor  = 8'd7;
            end else if (c + 1 == 20) begin
                dividend = 8'd50;
                divisor  = 8'hFD;
            end else begin
                dividend = 8'(c * 13 + 1);
                divisor  = 8'(c + 2);
            end
        end
        checks++;
        if (dcount !== 3) begin
            failures++;
            $display("FAIL b2b_done_count: got %0d, expected 3", dcount);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [7:0] q, r;
        logic       dz;
        int         lat, bn;
        int         seen;
        dividend = 8'd100;
        divisor  = 8'd7;
        en       = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        #1;
        checks++;
        if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got busy=%b done=%b q=%h r=%h dz=%b, expected all zero",
                     busy, done, quotient, remainder, div_by_zero);
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done: got %0d busy/done cycles, expected 0", seen);
        end
        run_op(8'd100, 8'd7, q, r, dz, lat, bn);
        checks++;
        if ({q, r, dz} !== {8'h0E, 8'h02, 1'b0} || lat !== 9) begin
            failures++;
            $display("FAIL reset_mid_rerun: got q=%h r=%h dz=%b lat=%0d, expected q=0e r=02 dz=0 lat=9",
                     q, r, dz, lat);
        end
    endtask

    // Every dividend against a spread of divisors, including zero and the extremes.
    task automatic test_sweep();
        logic [7:0] dv [0:15];
        logic [7:0] q, r, eq, er;
        logic       dz, edz;
        int         lat, bn;
        dv = '{8'h00, 8'h01, 8'hFF, 8'h02, 8'hFE, 8'h03, 8'hFD, 8'h07,
               8'hF9, 8'h7F, 8'h81, 8'h80, 8'h40, 8'hC0, 8'h0D, 8'h9C};
        for (int j = 0; j < 16; j++) begin
            for (int a = 0; a < 256; a++) begin
                run_op(8'(a), dv[j], q, r, dz, lat, bn);
                ref_div(8'(a), dv[j], eq, er, edz);
                checks++;
                if ({q, r, dz} !== {eq, er, edz} || lat !== 9) begin
                    failures++;
                    $display("FAIL sweep_%h_%h: got q=%h r=%h dz=%b lat=%0d, expected q=%h r=%h dz=%b lat=9",
                             8'(a), dv[j], q, r, dz, lat, eq, er, edz);
                end
            end
        end
    endtask

    initial begin
        rstn     = 1'b0;
        en       = 1'b0;
        dividend = '0;
        divisor  = '0;
        test_reset();
        test_basic();
        test_sign_matrix();
        test_corners();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
